// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: two-entry skid buffer (head M, skid S) with valid/ready
// handshake, plus load alignment/extension and a forwarding copy of the write enable.
module mem_wb_pipe #(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5,
    localparam int OFF_W         = $clog2(CPU_WIDTH/8)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [1:0]                wb_i,
    input  logic [2:0]                load_type_i,
    input  logic [OFF_W-1:0]          byte_off_i,
    input  logic [CPU_WIDTH-1:0]      mem_data_i,
    input  logic [CPU_WIDTH-1:0]      alu_result_i,
    input  logic [REG_ADDR_WIDTH-1:0] wreg_addr_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      reg_write_o,
    output logic [REG_ADDR_WIDTH-1:0] wreg_addr_o,
    output logic [CPU_WIDTH-1:0]      wb_data_o,
    output logic                      fwd_valid_o
);

    typedef struct packed {
        logic                      reg_write;
        logic                      memtoreg;
        logic [2:0]                load_type;
        logic [OFF_W-1:0]          byte_off;
        logic [CPU_WIDTH-1:0]      mem_data;
        logic [CPU_WIDTH-1:0]      alu_result;
        logic [REG_ADDR_WIDTH-1:0] wreg_addr;
    } entry_t;

    entry_t m, s, in;
    logic   m_v, s_v;
    logic   accept, pop;

    assign in = '{reg_write: wb_i[1], memtoreg: wb_i[0], load_type: load_type_i,
                  byte_off: byte_off_i, mem_data: mem_data_i,
                  alu_result: alu_result_i, wreg_addr: wreg_addr_i};

    // S.v is itself a flop, so ready is registered and depends on state only
    assign in_ready_o = !s_v;
    assign accept     = in_valid_i & !s_v;
    assign pop        = m_v & out_ready_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
            m   <= '0;
            s   <= '0;
        end else if (flush_i) begin
            m_v <= 1'b0;
            s_v <= 1'b0;
        end else if (!m_v) begin
            if (accept) begin
                m   <= in;
                m_v <= 1'b1;
            end
        end else if (!s_v) begin
            if (accept && pop) begin
                m <= in;
            end else if (accept) begin
                s   <= in;
                s_v <= 1'b1;
            end else if (pop) begin
                m_v <= 1'b0;
            end
        end else if (pop) begin
            m   <= s;
            s_v <= 1'b0;
        end
    end

    assign out_valid_o = m_v;
    assign reg_write_o = m_v & m.reg_write & (m.wreg_addr != '0);
    assign fwd_valid_o = reg_write_o;
    assign wreg_addr_o = m.wreg_addr;

    logic [CPU_WIDTH-1:0] sh, load_val, word_s, word_u;

    assign sh = m.mem_data >> {m.byte_off, 3'b000};

    // Word loads only need extension on the 64-bit datapath
    generate
        if (CPU_WIDTH == 64) begin : g_w64
            assign word_s = {{(CPU_WIDTH-32){sh[31]}}, sh[31:0]};
            assign word_u = {{(CPU_WIDTH-32){1'b0}}, sh[31:0]};
        end else begin : g_w32
            assign word_s = sh;
            assign word_u = sh;
        end
    endgenerate

    always_comb begin
        load_val = m.mem_data;
        case (m.load_type)
            3'b000:  load_val = {{(CPU_WIDTH-8){sh[7]}}, sh[7:0]};
            3'b001:  load_val = {{(CPU_WIDTH-16){sh[15]}}, sh[15:0]};
            3'b100:  load_val = {{(CPU_WIDTH-8){1'b0}}, sh[7:0]};
            3'b101:  load_val = {{(CPU_WIDTH-16){1'b0}}, sh[15:0]};
            3'b010:  load_val = word_s;
            3'b110:  load_val = word_u;
            default: load_val = m.mem_data;
        endcase
    end

    assign wb_data_o = m.memtoreg ? load_val : m.alu_result;

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: a 32-bit and a 64-bit instance share control inputs.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rstn, flush, in_valid, out_ready;
    logic [1:0]  wb;
    logic [2:0]  load_type;
    logic [1:0]  off32;
    logic [2:0]  off64;
    logic [31:0] mem32, alu32;
    logic [63:0] mem64, alu64;
    logic [4:0]  waddr;

    logic        rdy32, ov32, rw32, fv32;
    logic [4:0]  wa32;
    logic [31:0] wd32;
    logic        rdy64, ov64, rw64, fv64;
    logic [4:0]  wa64;
    logic [63:0] wd64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_pipe #(.CPU_WIDTH(32), .REG_ADDR_WIDTH(5)) dut32 (
        .clk(clk), .rstn(rstn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy32),
        .wb_i(wb), .load_type_i(load_type), .byte_off_i(off32), .mem_data_i(mem32),
        .alu_result_i(alu32), .wreg_addr_i(waddr), .out_valid_o(ov32), .out_ready_i(out_ready),
        .reg_write_o(rw32), .wreg_addr_o(wa32), .wb_data_o(wd32), .fwd_valid_o(fv32));

    mem_wb_pipe #(.CPU_WIDTH(64), .REG_ADDR_WIDTH(5)) dut64 (
        .clk(clk), .rstn(rstn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy64),
        .wb_i(wb), .load_type_i(load_type), .byte_off_i(off64), .mem_data_i(mem64),
        .alu_result_i(alu64), .wreg_addr_i(waddr), .out_valid_o(ov64), .out_ready_i(out_ready),
        .reg_write_o(rw64), .wreg_addr_o(wa64), .wb_data_o(wd64), .fwd_valid_o(fv64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] w, input logic [31:0] alu,
                         input logic [4:0] a);
        in_valid = v; wb = w; alu32 = alu; alu64 = {32'h0, alu}; waddr = a;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 2'b00, 32'h0, 5'd0);
        load_type = 3'b000; off32 = 2'd0; off64 = 3'd0; mem32 = '0; mem64 = '0;
        #12;
        chk("rst_out_valid", {63'h0, ov32}, 64'd0);
        chk("rst_reg_write", {63'h0, rw32}, 64'd0);
        chk("rst_fwd_valid", {63'h0, fv32}, 64'd0);
        chk("rst_in_ready", {63'h0, rdy32}, 64'd1);
        chk("rst_wreg_addr", {59'h0, wa32}, 64'd0);
        chk("rst_wb_data", {32'h0, wd32}, 64'd0);

        // Streaming ALU results
        @(negedge clk); rstn = 1'b1; out_ready = 1'b1;
        drive(1'b1, 2'b10, 32'h11, 5'd5); tick();
        chk("s1_data", {32'h0, wd32}, 64'h11);
        chk("s1_addr", {59'h0, wa32}, 64'd5);
        chk("s1_rw", {63'h0, rw32}, 64'd1);
        drive(1'b1, 2'b10, 32'h22, 5'd6); tick();
        chk("s2_data", {32'h0, wd32}, 64'h22);
        chk("s2_addr", {59'h0, wa32}, 64'd6);
        drive(1'b1, 2'b10, 32'h33, 5'd7); tick();
        chk("s3_data", {32'h0, wd32}, 64'h33);
        chk("s3_rw", {63'h0, rw32}, 64'd1);
        drive(1'b0, 2'b10, 32'h0, 5'd0); tick();
        chk("s_drain", {63'h0, ov32}, 64'd0);

        // Stall: A into M, B into S, C refused
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 32'hA, 5'd8); tick();
        chk("st_a_ready", {63'h0, rdy32}, 64'd1);
        drive(1'b1, 2'b10, 32'hB, 5'd9); tick();
        chk("st_b_ready", {63'h0, rdy32}, 64'd0);
        chk("st_b_head", {32'h0, wd32}, 64'hA);
        drive(1'b1, 2'b10, 32'hC, 5'd10); tick();
        chk("st_c_head", {32'h0, wd32}, 64'hA);
        chk("st_c_ready", {63'h0, rdy32}, 64'd0);
        out_ready = 1'b1; tick();
        chk("rel_b", {32'h0, wd32}, 64'hB);
        chk("rel_ready", {63'h0, rdy32}, 64'd1);
        tick();
        chk("rel_c", {32'h0, wd32}, 64'hC);
        chk("rel_c_addr", {59'h0, wa32}, 64'd10);
        drive(1'b0, 2'b10, 32'h0, 5'd0); tick();
        chk("rel_drain", {63'h0, ov32}, 64'd0);

        // 32-bit load extension, streaming
        drive(1'b1, 2'b11, 32'h0, 5'd1); mem32 = 32'h8081_F2F3;
        load_type = 3'b000; off32 = 2'd1; tick();
        chk("lb_off1", {32'h0, wd32}, 64'hFFFF_FFF2);
        load_type = 3'b100; off32 = 2'd3; tick();
        chk("lbu_off3", {32'h0, wd32}, 64'h0000_0080);
        load_type = 3'b001; off32 = 2'd2; tick();
        chk("lh_off2", {32'h0, wd32}, 64'hFFFF_8081);
        load_type = 3'b101; off32 = 2'd0; tick();
        chk("lhu_off0", {32'h0, wd32}, 64'h0000_F2F3);
        load_type = 3'b010; off32 = 2'd0; tick();
        chk("lw_32", {32'h0, wd32}, 64'h8081_F2F3);

        // 64-bit load extension
        mem64 = 64'hFEDC_BA98_7654_3210; off64 = 3'd4;
        load_type = 3'b010; tick();
        chk("lw_off4_64", wd64, 64'hFFFF_FFFF_FEDC_BA98);
        load_type = 3'b110; tick();
        chk("lwu_off4_64", wd64, 64'h0000_0000_FEDC_BA98);
        load_type = 3'b011; off64 = 3'd0; tick();
        chk("ld_64", wd64, 64'hFEDC_BA98_7654_3210);

        // Writes to x0 suppressed
        drive(1'b1, 2'b10, 32'h55, 5'd0); tick();
        chk("x0_valid", {63'h0, ov32}, 64'd1);
        chk("x0_rw", {63'h0, rw32}, 64'd0);
        chk("x0_fwd", {63'h0, fv32}, 64'd0);
        drive(1'b0, 2'b10, 32'h0, 5'd0); tick();

        // Flush in FULL with a concurrent offer
        out_ready = 1'b0;
        drive(1'b1, 2'b10, 32'hD, 5'd11); tick();
        drive(1'b1, 2'b10, 32'hE, 5'd12); tick();
        chk("fl_full", {63'h0, rdy32}, 64'd0);
        flush = 1'b1; drive(1'b1, 2'b10, 32'hF, 5'd13); tick();
        chk("fl_valid", {63'h0, ov32}, 64'd0);
        chk("fl_ready", {63'h0, rdy32}, 64'd1);
        chk("fl_rw", {63'h0, rw32}, 64'd0);
        flush = 1'b0; drive(1'b0, 2'b10, 32'h0, 5'd0); tick();
        chk("fl_discard", {63'h0, ov32}, 64'd0);

        // Asynchronous reset mid-operation
        drive(1'b1, 2'b10, 32'h77, 5'd3); tick();
        chk("ar_pre", {63'h0, rw32}, 64'd1);
        #2 rstn = 1'b0; #1;
        chk("ar_valid", {63'h0, ov32}, 64'd0);
        chk("ar_rw", {63'h0, rw32}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
